// File: rtl/psum_accum_bank_if.sv
// psum_accum_bank_if: control, input-beat and output-beat signals of the partial-sum accumulator bank.
interface psum_accum_bank_if #(
  parameter int NUM_ROWS      = 5,
  parameter int DATA_W        = 25,
  parameter int OUT_W         = 25,
  parameter int NUM_OUT_PORTS = 2,
  parameter int PASS_W        = 4
);
  logic                            start;
  logic                            abort;
  logic [PASS_W-1:0]               cfg_passes;
  logic                            cfg_relu;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_ROWS*DATA_W-1:0]      in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_OUT_PORTS*OUT_W-1:0]  out_data;
  logic [NUM_OUT_PORTS-1:0]        out_lane_v;
  logic                            busy;
  logic                            done;
  modport master (
    output start, abort, cfg_passes, cfg_relu, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane_v, busy, done
  );
  modport slave (
    input  start, abort, cfg_passes, cfg_relu, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane_v, busy, done
  );
endinterface

// File: rtl/psum_accum_bank.sv
// psum_accum_bank: multi-pass signed partial-sum accumulator with ReLU/saturating drain over a valid/ready stream.
module psum_accum_bank #(
  parameter int NUM_ROWS      = 5,
  parameter int DATA_W        = 25,
  parameter int ACC_W         = 32,
  parameter int OUT_W         = 25,
  parameter int DEPTH         = 16,
  parameter int NUM_OUT_PORTS = 2,
  parameter int PASS_W        = 4
) (
  input logic clk,
  input logic rst,
  psum_accum_bank_if.slave bus
);
  localparam int TOTAL = NUM_ROWS * DEPTH;
  localparam int NB = (TOTAL + NUM_OUT_PORTS - 1) / NUM_OUT_PORTS;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
  localparam int BW = $clog2(NB + 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state;
  logic [IW-1:0] wr_idx;
  logic [PASS_W-1:0] pass_cnt, passes;
  logic relu;
  logic [BW-1:0] beat, ld_beat;
  logic signed [ACC_W-1:0] acc [NUM_ROWS][DEPTH];
  logic signed [ACC_W-1:0] new_sum [NUM_ROWS];
  logic accept, wrap, take;
  logic [NUM_OUT_PORTS*OUT_W-1:0] nxt_data;
  logic [NUM_OUT_PORTS-1:0] nxt_lv;
  function automatic logic [OUT_W-1:0] post(input logic signed [ACC_W-1:0] v, input logic rl);
    return (rl && v[ACC_W-1]) ? '0 : v > SMAX ? SMAX[OUT_W-1:0] : v < SMIN ? SMIN[OUT_W-1:0] : v[OUT_W-1:0];
  endfunction
  assign bus.in_ready = state == ACCUM;
  assign bus.busy = state != IDLE;
  assign accept = bus.in_valid && state == ACCUM;
  assign wrap = accept && wr_idx == IW'(DEPTH - 1);
  assign take = bus.out_valid && bus.out_ready;
  assign ld_beat = state == DRAIN ? beat + 1'b1 : '0;
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    assign new_sum[g] = (pass_cnt == '0 ? '0 : acc[g][wr_idx]) + ACC_W'($signed(bus.in_data[g*DATA_W +: DATA_W]));
    always_ff @(posedge clk)
      if (accept) acc[g][wr_idx] <= new_sum[g];
  end
  // The first beat is loaded on the same edge as the final write, so that entry is forwarded from new_sum.
  always_comb begin
    nxt_data = '0;
    nxt_lv = '0;
    for (int p = 0; p < NUM_OUT_PORTS; p++) begin
      int e;
      logic [RW-1:0] row;
      logic [IW-1:0] idx;
      logic signed [ACC_W-1:0] v;
      e = int'(ld_beat) * NUM_OUT_PORTS + p;
      row = RW'(e / DEPTH);
      idx = IW'(e % DEPTH);
      v = (accept && idx == wr_idx) ? new_sum[row] : acc[row][idx];
      nxt_lv[p] = e < TOTAL;
      nxt_data[p*OUT_W +: OUT_W] = e < TOTAL ? post(v, relu) : '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_idx <= '0;
      pass_cnt <= '0;
      passes <= '0;
      relu <= 1'b0;
      beat <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_lane_v <= '0;
      bus.done <= 1'b0;
    end else if (bus.abort) begin
      state <= IDLE;
      wr_idx <= '0;
      pass_cnt <= '0;
      beat <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_lane_v <= '0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= ACCUM;
          passes <= bus.cfg_passes;
          relu <= bus.cfg_relu;
          wr_idx <= '0;
          pass_cnt <= '0;
        end
        ACCUM: if (accept) begin
          wr_idx <= wrap ? '0 : wr_idx + 1'b1;
          if (wrap) pass_cnt <= pass_cnt + 1'b1;
          if (wrap && pass_cnt == passes) begin
            state <= DRAIN;
            beat <= '0;
            bus.out_valid <= 1'b1;
            bus.out_data <= nxt_data;
            bus.out_lane_v <= nxt_lv;
          end
        end
        DRAIN: if (take) begin
          if (beat == BW'(NB - 1)) begin
            state <= DONE;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_lane_v <= '0;
            bus.done <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
            bus.out_data <= nxt_data;
            bus.out_lane_v <= nxt_lv;
          end
        end
        default: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_psum_accum_bank.sv
// tb_psum_accum_bank: directed checks of accumulation, post-processing, drain handshake, abort and reset.
module tb_psum_accum_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  psum_accum_bank_if a ();
  psum_accum_bank_if b ();
  psum_accum_bank u_dut (.clk(clk), .rst(rst), .bus(a.slave));
  psum_accum_bank #(.DEPTH(3)) u_small (.clk(clk), .rst(rst), .bus(b.slave));
  int cmp = 0;
  int mis = 0;
  int got[$];
  int nb;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [124:0] lanes(input int v);
    logic [124:0] x;
    for (int r = 0; r < 5; r++) x[r*25 +: 25] = 25'(v);
    return x;
  endfunction
  function automatic logic [124:0] ramp(input int i, input int k);
    logic [124:0] x;
    for (int r = 0; r < 5; r++) x[r*25 +: 25] = 25'(r * k + i);
    return x;
  endfunction
  task automatic start_job(input int passes, input logic relu);
    a.cfg_passes = 4'(passes);
    a.cfg_relu = relu;
    a.start = 1'b1;
    step;
    a.start = 1'b0;
  endtask
  task automatic feed(input int n, input int mode, input int v, input int glitch);
    for (int i = 0; i < n; i++) begin
      a.in_data = mode == 0 ? ramp(i % 16, 100) : lanes(v);
      a.in_valid = 1'b1;
      if (i == glitch) begin
        a.start = 1'b1;
        a.cfg_passes = 4'd7;
        a.cfg_relu = 1'b1;
      end
      step;
      a.start = 1'b0;
    end
    a.in_valid = 1'b0;
  endtask
  task automatic drain(input int stall_at);
    int prev, donecyc;
    logic [49:0] snap;
    got.delete();
    nb = 0;
    prev = -2;
    donecyc = -1;
    a.out_ready = 1'b1;
    for (int c = 0; c < 300 && donecyc < 0; c++) begin
      if (a.out_valid && nb == stall_at) begin
        snap = a.out_data;
        a.out_ready = 1'b0;
        a.in_valid = 1'b1;
        a.in_data = lanes(999);
        repeat (5) begin
          step;
          chk("stall_hold", {a.out_valid, a.out_data}, {1'b1, snap});
          chk("drain_in_ready", a.in_ready, 0);
        end
        a.out_ready = 1'b1;
        a.in_valid = 1'b0;
        stall_at = -1;
      end
      if (a.out_valid) begin
        for (int p = 0; p < 2; p++) got.push_back(int'($signed(a.out_data[p*25 +: 25])));
        nb++;
        prev = c;
      end
      step;
      if (a.done) donecyc = c;
    end
    chk("done_seen", donecyc >= 0, 1);
    chk("done_after_last", donecyc, prev);
    a.out_ready = 1'b0;
    step;
    chk("done_one_cycle", {a.done, a.busy}, 0);
  endtask
  task automatic expect_all(input string tag, input int v);
    int errs = 0;
    if (got.size() != 80) errs++;
    foreach (got[k]) if (got[k] != v) errs++;
    chk(tag, errs, 0);
  endtask
  task automatic expect_ramp(input string tag);
    int errs = 0;
    if (got.size() != 80) errs++;
    foreach (got[k]) if (got[k] != (k / 16) * 100 + k % 16) errs++;
    chk(tag, errs, 0);
  endtask
  initial begin
    int nbs, errs, e;
    logic [1:0] last_lv;
    logic [49:0] last_d;
    a.start = 0; a.abort = 0; a.cfg_passes = 0; a.cfg_relu = 0;
    a.in_valid = 0; a.in_data = '0; a.out_ready = 0;
    b.start = 0; b.abort = 0; b.cfg_passes = 0; b.cfg_relu = 0;
    b.in_valid = 0; b.in_data = '0; b.out_ready = 0;
    step;
    step;
    chk("rst_ctrl", {a.in_ready, a.out_valid, a.out_lane_v, a.busy, a.done}, 0);
    chk("rst_data", a.out_data, 0);
    rst = 1'b0;
    start_job(0, 1'b0);
    chk("accum_busy_ready", {a.busy, a.in_ready}, 2'b11);
    feed(16, 0, 0, -1);
    chk("first_beat_valid", {a.out_valid, a.out_lane_v, a.in_ready}, 4'b1110);
    drain(-1);
    chk("ramp_beats", nb, 40);
    chk("ramp_b0_l0", got[0], 0);
    chk("ramp_b0_l1", got[1], 1);
    chk("ramp_b8_l0", got[16], 100);
    chk("ramp_b8_l1", got[17], 101);
    chk("ramp_b39_l0", got[78], 414);
    chk("ramp_b39_l1", got[79], 415);
    expect_ramp("ramp_all");
    start_job(3, 1'b0);
    feed(64, 1, -5, -1);
    drain(-1);
    chk("neg_b0", got[0], -20);
    expect_all("neg_all", -20);
    start_job(3, 1'b1);
    feed(64, 1, -5, -1);
    drain(-1);
    expect_all("relu_all", 0);
    start_job(1, 1'b0);
    feed(32, 1, (1 << 24) - 1, -1);
    drain(-1);
    chk("sat_pos_b0", got[0], 16777215);
    expect_all("sat_pos_all", 16777215);
    start_job(1, 1'b0);
    feed(32, 1, -(1 << 24), -1);
    drain(-1);
    expect_all("sat_neg_all", -16777216);
    start_job(0, 1'b0);
    feed(16, 0, 0, 5);
    chk("start_in_accum_ignored", a.out_valid, 1);
    drain(10);
    chk("stall_beats", nb, 40);
    expect_ramp("stall_ramp_all");
    start_job(0, 1'b0);
    feed(7, 0, 0, -1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {a.in_ready, a.out_valid, a.out_lane_v, a.busy, a.done}, 0);
    chk("rst_mid_data", a.out_data, 0);
    step;
    rst = 1'b0;
    start_job(1, 1'b0);
    feed(32, 0, 0, -1);
    a.out_ready = 1'b1;
    repeat (3) step;
    a.out_ready = 1'b0;
    chk("pre_abort_valid", a.out_valid, 1);
    a.abort = 1'b1;
    a.start = 1'b1;
    step;
    a.abort = 1'b0;
    a.start = 1'b0;
    chk("abort_idle", {a.out_valid, a.busy, a.done}, 0);
    step;
    chk("abort_no_done", {a.done, a.busy}, 0);
    start_job(0, 1'b0);
    feed(16, 1, 7, -1);
    drain(-1);
    expect_all("post_abort_fresh", 7);
    b.start = 1'b1;
    step;
    b.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b.in_data = ramp(i, 10);
      b.in_valid = 1'b1;
      step;
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    nbs = 0;
    errs = 0;
    last_lv = '0;
    last_d = '0;
    for (int c = 0; c < 40 && !b.done; c++) begin
      if (b.out_valid) begin
        for (int p = 0; p < 2; p++) begin
          e = nbs * 2 + p;
          if (e < 15 && int'($signed(b.out_data[p*25 +: 25])) != (e / 3) * 10 + e % 3) errs++;
        end
        last_lv = b.out_lane_v;
        last_d = b.out_data;
        nbs++;
      end
      step;
    end
    b.out_ready = 1'b0;
    chk("small_done", b.done, 1);
    chk("small_beats", nbs, 8);
    chk("small_last_lane_v", last_lv, 2'b01);
    chk("small_last_data", last_d, {25'd0, 25'd42});
    chk("small_elems", errs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
